// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key path: symbol codes (also used by the
// downstream decoder), sequencer state encoding and duration helpers.
package morse_pkg;

   localparam logic [1:0] SYM_DOT        = 2'b00;
   localparam logic [1:0] SYM_DASH       = 2'b01;
   localparam logic [1:0] SYM_LETTER_END = 2'b10;
   localparam logic [1:0] SYM_WORD_END   = 2'b11;

   localparam int          DUR_W   = 16;
   localparam logic [15:0] DUR_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_PRESS      = 2'd1,
      ST_GAP_LETTER = 2'd2,
      ST_GAP_WORD   = 2'd3
   } state_e;

   // Saturating increment: the duration counter must never wrap.
   function automatic logic [15:0] dur_sat_inc(input logic [15:0] d);
      logic [15:0] r;
      if (d == DUR_MAX) begin
         r = d;
      end else begin
         r = d + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick divider; restart realigns the tick phase to a key edge.
module ms_tick_gen #(
   parameter int CLK_FREQ = 100_000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int             DIV  = CLK_FREQ / 1000;
   localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(DIV - 1);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt_s;
   logic          tick_r;

   // Next divider count, cleared on reset or restart, wrapping at the terminal value.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (rst || restart) begin
         cnt_nxt_s = '0;
      end else if (cnt_r == TERM) begin
         cnt_nxt_s = '0;
      end else begin
         cnt_nxt_s = cnt_r + CW'(1);
      end
   end

   // Divider count and registered terminal-count tick.
   always_ff @(posedge clk) begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= (cnt_nxt_s == TERM);
   end

   assign tick = tick_r;

endmodule

// File: rtl/morse_key_sequencer.sv
// Turns debounced key activity into DOT/DASH/LETTER_END/WORD_END symbols,
// timed in ms, delivered through a single-entry valid/ready output register.
module morse_key_sequencer
   import morse_pkg::*;
#(
   parameter int CLK_FREQ      = 100_000,
   parameter int DOT_MAX_MS    = 200,
   parameter int LETTER_GAP_MS = 600,
   parameter int WORD_GAP_MS   = 1400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_level,
   output logic       sym_valid,
   input  logic       sym_ready,
   output logic [1:0] sym_code,
   output logic       overflow,
   input  logic       ovf_clr,
   output logic       busy
);

   localparam logic [15:0] DOT_LIM    = 16'(DOT_MAX_MS);
   localparam logic [15:0] LETTER_LIM = 16'(LETTER_GAP_MS);
   localparam logic [15:0] WORD_LIM   = 16'(WORD_GAP_MS);

   state_e      state_r;
   logic        btn_prev_r;
   logic [15:0] dur_r;
   logic        sym_valid_r;
   logic [1:0]  sym_code_r;
   logic        overflow_r;
   logic        busy_r;

   logic        rise_s;
   logic        fall_s;
   logic        tick_s;
   logic [15:0] elapsed_s;
   logic        emit_s;
   logic [1:0]  emit_code_s;
   logic        accept_s;

   assign rise_s = btn_level & ~btn_prev_r;
   assign fall_s = ~btn_level & btn_prev_r;

   ms_tick_gen #(
      .CLK_FREQ (CLK_FREQ)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (rise_s | fall_s),
      .tick    (tick_s)
   );

   // Elapsed ms including a tick landing this cycle, so a press of exactly N ms reads N.
   always_comb begin
      elapsed_s = dur_r;
      if (tick_s) begin
         elapsed_s = dur_sat_inc(dur_r);
      end else begin
         elapsed_s = dur_r;
      end
   end

   // Symbol request decode; a rise in a gap suppresses the threshold emit.
   always_comb begin
      emit_s      = 1'b0;
      emit_code_s = SYM_DOT;
      case (state_r)
         ST_PRESS: begin
            if (fall_s) begin
               emit_s      = 1'b1;
               emit_code_s = (elapsed_s < DOT_LIM) ? SYM_DOT : SYM_DASH;
            end else begin
               emit_s = 1'b0;
            end
         end
         ST_GAP_LETTER: begin
            if (!rise_s && (elapsed_s >= LETTER_LIM)) begin
               emit_s      = 1'b1;
               emit_code_s = SYM_LETTER_END;
            end else begin
               emit_s = 1'b0;
            end
         end
         ST_GAP_WORD: begin
            if (!rise_s && (elapsed_s >= WORD_LIM)) begin
               emit_s      = 1'b1;
               emit_code_s = SYM_WORD_END;
            end else begin
               emit_s = 1'b0;
            end
         end
         default: begin
            emit_s = 1'b0;
         end
      endcase
   end

   assign accept_s = ~sym_valid_r | sym_ready;

   // Sequencer FSM, duration counter and single-entry output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         btn_prev_r  <= 1'b1;
         dur_r       <= 16'd0;
         sym_valid_r <= 1'b0;
         sym_code_r  <= SYM_DOT;
         overflow_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         btn_prev_r <= btn_level;

         if (rise_s || fall_s) begin
            dur_r <= 16'd0;
         end else if (tick_s) begin
            dur_r <= dur_sat_inc(dur_r);
         end else begin
            dur_r <= dur_r;
         end

         case (state_r)
            ST_IDLE: begin
               if (rise_s) begin
                  state_r <= ST_PRESS;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            ST_PRESS: begin
               busy_r <= 1'b1;
               if (fall_s) begin
                  state_r <= ST_GAP_LETTER;
               end
            end
            ST_GAP_LETTER: begin
               busy_r <= 1'b1;
               if (rise_s) begin
                  state_r <= ST_PRESS;
               end else if (emit_s) begin
                  state_r <= ST_GAP_WORD;
               end
            end
            ST_GAP_WORD: begin
               if (rise_s) begin
                  state_r <= ST_PRESS;
                  busy_r  <= 1'b1;
               end else if (emit_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase

         // A refused emit leaves the held symbol untouched and flags the loss.
         if (emit_s && accept_s) begin
            sym_valid_r <= 1'b1;
            sym_code_r  <= emit_code_s;
         end else if (sym_valid_r && sym_ready) begin
            sym_valid_r <= 1'b0;
         end

         if (emit_s && !accept_s) begin
            overflow_r <= 1'b1;
         end else if (ovf_clr) begin
            overflow_r <= 1'b0;
         end
      end
   end

   assign sym_valid = sym_valid_r;
   assign sym_code  = sym_code_r;
   assign overflow  = overflow_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Self-checking bench: directed scenarios plus random key activity, compared
// every cycle against an interval-based reference model.
module tb_morse_key_sequencer;
   import morse_pkg::*;

   localparam int CLK_FREQ = 4000;
   localparam int DIV      = CLK_FREQ / 1000;
   localparam int DOT_MS   = 20;
   localparam int LET_MS   = 60;
   localparam int WORD_MS  = 140;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_level;
   logic       sym_valid;
   logic       sym_ready;
   logic [1:0] sym_code;
   logic       overflow;
   logic       ovf_clr;
   logic       busy;

   always #5 clk = ~clk;

   morse_key_sequencer #(
      .CLK_FREQ      (CLK_FREQ),
      .DOT_MAX_MS    (DOT_MS),
      .LETTER_GAP_MS (LET_MS),
      .WORD_GAP_MS   (WORD_MS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_level (btn_level),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym_code  (sym_code),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr),
      .busy      (busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the key history is a set of intervals measured in whole ms
   // from the last edge; pending closures are plain flags.
   int unsigned ncyc      = 0;
   int unsigned edge_cyc  = 0;
   bit          m_prev    = 1'b1;
   bit          m_pressing = 1'b0;
   bit          m_letter_open = 1'b0;
   bit          m_word_open   = 1'b0;
   bit          m_valid   = 1'b0;
   bit          m_ovf     = 1'b0;
   logic [1:0]  m_code    = 2'b00;
   logic [1:0]  got_q[$];

   task automatic model_step(input bit b, input bit r, input bit c, input bit rs);
      int unsigned ms;
      bit          rise, fall, emit, drop;
      logic [1:0]  ecode;
      if (rs) begin
         m_prev = 1'b1; m_pressing = 1'b0; m_letter_open = 1'b0; m_word_open = 1'b0;
         m_valid = 1'b0; m_ovf = 1'b0; m_code = 2'b00;
         edge_cyc = ncyc;
      end else begin
         rise  = b && !m_prev;
         fall  = !b && m_prev;
         ms    = (ncyc - edge_cyc) / DIV;
         if (ms > 65535) ms = 65535;
         emit  = 1'b0;
         ecode = 2'b00;
         drop  = 1'b0;
         if (m_pressing) begin
            if (fall) begin
               emit = 1'b1;
               ecode = (ms < DOT_MS) ? SYM_DOT : SYM_DASH;
               m_pressing = 1'b0;
               m_letter_open = 1'b1;
            end
         end else if (rise) begin
            m_pressing = 1'b1;
            m_letter_open = 1'b0;
            m_word_open = 1'b0;
         end else if (m_letter_open && ms >= LET_MS) begin
            emit = 1'b1; ecode = SYM_LETTER_END;
            m_letter_open = 1'b0; m_word_open = 1'b1;
         end else if (m_word_open && ms >= WORD_MS) begin
            emit = 1'b1; ecode = SYM_WORD_END;
            m_word_open = 1'b0;
         end
         if (rise || fall) edge_cyc = ncyc;
         m_prev = b;
         if (emit) begin
            if (!m_valid || r) begin
               m_valid = 1'b1;
               m_code  = ecode;
            end else begin
               drop = 1'b1;
            end
         end else if (m_valid && r) begin
            m_valid = 1'b0;
         end
         if (drop) m_ovf = 1'b1;
         else if (c) m_ovf = 1'b0;
      end
      ncyc++;
   endtask

   task automatic step(input bit b, input bit r, input bit c, input bit rs);
      btn_level = b; sym_ready = r; ovf_clr = c; rst = rs;
      if (!rs && sym_valid === 1'b1 && r) got_q.push_back(sym_code);
      model_step(b, r, c, rs);
      @(posedge clk);
      #1;
      check_eq("sym_valid", {15'd0, sym_valid}, {15'd0, m_valid});
      check_eq("sym_code",  {14'd0, sym_code},  {14'd0, m_code});
      check_eq("overflow",  {15'd0, overflow},  {15'd0, m_ovf});
      check_eq("busy",      {15'd0, busy},      {15'd0, m_pressing | m_letter_open | m_word_open});
   endtask

   task automatic hold(input int n, input bit b, input bit r);
      for (int i = 0; i < n; i++) step(b, r, 1'b0, 1'b0);
   endtask

   // Compare the handshaken symbol history with an expected list (first symbol in bits [1:0]).
   task automatic expect_syms(input string tag, input int n, input logic [7:0] seq);
      check_eq({tag, "_count"}, 16'(got_q.size()), 16'(n));
      if (got_q.size() == n) begin
         for (int i = 0; i < n; i++) begin
            check_eq({tag, "_sym"}, {14'd0, got_q[i]}, {14'd0, seq[2*i +: 2]});
         end
      end
      got_q.delete();
   endtask

   initial begin
      // Key held through reset must not start a press.
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check_eq("rst_valid", {15'd0, sym_valid}, 16'd0);
      check_eq("rst_busy",  {15'd0, busy},      16'd0);
      hold(30, 1'b1, 1'b1);
      hold(20, 1'b0, 1'b1);
      check_eq("held_busy", {15'd0, busy}, 16'd0);
      expect_syms("held", 0, 8'h00);

      // Single dot with both gap closures.
      hold(10 * DIV, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("dot_latency", {14'd0, sym_code}, {14'd0, SYM_DOT});
      hold(WORD_MS * DIV + 10, 1'b0, 1'b1);
      check_eq("dot_idle", {15'd0, busy}, 16'd0);
      expect_syms("single", 3, {2'b00, SYM_WORD_END, SYM_LETTER_END, SYM_DOT});

      // Dot/dash boundary.
      hold(DOT_MS * DIV - 1, 1'b1, 1'b1);
      hold(WORD_MS * DIV + 5, 1'b0, 1'b1);
      expect_syms("b19x", 3, {2'b00, SYM_WORD_END, SYM_LETTER_END, SYM_DOT});
      hold(DOT_MS * DIV, 1'b1, 1'b1);
      hold(WORD_MS * DIV + 5, 1'b0, 1'b1);
      expect_syms("b20", 3, {2'b00, SYM_WORD_END, SYM_LETTER_END, SYM_DASH});

      // Intra-letter gap.
      hold(10 * DIV, 1'b1, 1'b1);
      hold(30 * DIV, 1'b0, 1'b1);
      hold(30 * DIV, 1'b1, 1'b1);
      hold(WORD_MS * DIV + 5, 1'b0, 1'b1);
      expect_syms("intra", 4, {SYM_WORD_END, SYM_LETTER_END, SYM_DASH, SYM_DOT});

      // Backpressure: DOT held, LETTER_END dropped.
      hold(10 * DIV, 1'b1, 1'b0);
      hold(70 * DIV, 1'b0, 1'b0);
      check_eq("bp_code",  {14'd0, sym_code}, {14'd0, SYM_DOT});
      check_eq("bp_ovf",   {15'd0, overflow}, 16'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("bp_clr",   {15'd0, overflow}, 16'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("bp_drain", {15'd0, sym_valid}, 16'd0);
      hold(WORD_MS * DIV, 1'b0, 1'b1);
      expect_syms("bp", 2, {4'h0, SYM_WORD_END, SYM_DOT});

      // Reset mid-press: nothing emitted, later release ignored.
      hold(10 * DIV, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      hold(5 * DIV, 1'b1, 1'b1);
      hold(20 * DIV, 1'b0, 1'b1);
      check_eq("rmid_busy", {15'd0, busy}, 16'd0);
      expect_syms("rmid", 0, 8'h00);
      hold(5 * DIV, 1'b1, 1'b1);
      hold(WORD_MS * DIV + 5, 1'b0, 1'b1);
      expect_syms("rmid_dot", 3, {2'b00, SYM_WORD_END, SYM_LETTER_END, SYM_DOT});

      // Rise on the exact letter-threshold cycle.
      hold(10 * DIV, 1'b1, 1'b1);
      hold(LET_MS * DIV, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("coin_busy", {15'd0, busy}, 16'd1);
      expect_syms("coin", 1, {6'h0, SYM_DOT});
      hold(10 * DIV, 1'b1, 1'b1);
      hold(WORD_MS * DIV + 5, 1'b0, 1'b1);
      expect_syms("coin_tail", 3, {2'b00, SYM_WORD_END, SYM_LETTER_END, SYM_DOT});

      // Random key activity, ready and clear.
      for (int seg = 0; seg < 60; seg++) begin
         int len;
         bit lvl;
         lvl = seg[0] ? 1'b0 : 1'b1;
         len = int'($urandom_range(1, WORD_MS * DIV + 40));
         for (int i = 0; i < len; i++) begin
            step(lvl, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0), 1'b0);
         end
      end
      hold(WORD_MS * DIV + 5, 1'b0, 1'b1);
      check_eq("final_busy", {15'd0, busy}, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
